// File: rtl/input_p4_interface_pkg.sv
// Shared constants for the P4 ingress dispatcher: FSM encodings, 802.1Q header
// offsets, buffer sizing and the log2 helper used to size the ingress FIFO.
package input_p4_interface_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [15:0] VLAN_TPID = 16'h8100;

    // Bit offsets of the tag fields within the first beat (byte n = tdata[8n+7:8n]).
    localparam int VLAN_HDR_LSB = 96;
    localparam int TPID_HI_LSB  = 96;
    localparam int TPID_LO_LSB  = 104;
    localparam int VID_HI_LSB   = 112;
    localparam int VID_LO_LSB   = 120;

    localparam int MAX_PKT_SIZE = 2000;

    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// First-word-fallthrough FIFO: the head word is visible on dout whenever empty is low.
// Pointers clear asynchronously on reset so a flush takes effect immediately.
module fallthrough_small_fifo #(
    parameter int WIDTH               = 72,
    parameter int MAX_DEPTH_BITS      = 3,
    parameter int PROG_FULL_THRESHOLD = 2**MAX_DEPTH_BITS - 1
)(
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             prog_full,
    output logic             empty,
    input  logic             reset,
    input  logic             clk
);
    localparam int DEPTH = 2**MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] DEPTH_W   = (MAX_DEPTH_BITS+1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] NFULL_W   = (MAX_DEPTH_BITS+1)'(DEPTH - 1);
    localparam logic [MAX_DEPTH_BITS:0] PFULL_W   = (MAX_DEPTH_BITS+1)'(PROG_FULL_THRESHOLD);

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q;
    logic [MAX_DEPTH_BITS:0]   count_q;
    logic                      do_wr;
    logic                      do_rd;

    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout        = mem[rd_ptr_q];
    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_W);
    assign nearly_full = (count_q >= NFULL_W);
    assign prog_full   = (count_q >= PFULL_W);

endmodule

// File: rtl/input_p4_decode.sv
// Maps the 802.1Q tag of a packet's first beat to {drop, dst}; untagged traffic
// goes to DEFAULT_QUEUE, tagged traffic with an out-of-range VID is dropped.
module input_p4_decode
    import input_p4_interface_pkg::*;
#(
    parameter int NUM_QUEUES    = 5,
    parameter int DEFAULT_QUEUE = 0
)(
    input  logic [31:0] vlan_hdr,
    output logic        drop,
    output logic [2:0]  dst
);
    logic [15:0] tpid;
    logic [11:0] vid;
    logic [3:0]  unused_pcp_dei;

    assign tpid = {vlan_hdr[TPID_HI_LSB-VLAN_HDR_LSB +: 8], vlan_hdr[TPID_LO_LSB-VLAN_HDR_LSB +: 8]};
    assign vid  = {vlan_hdr[VID_HI_LSB-VLAN_HDR_LSB +: 4], vlan_hdr[VID_LO_LSB-VLAN_HDR_LSB +: 8]};
    assign unused_pcp_dei = vlan_hdr[VID_HI_LSB-VLAN_HDR_LSB+4 +: 4];

    always_comb begin
        drop = 1'b0;
        dst  = 3'(DEFAULT_QUEUE);
        if (tpid == VLAN_TPID) begin
            if (vid < 12'(NUM_QUEUES)) dst = vid[2:0];
            else                       drop = 1'b1;
        end
    end

endmodule

// File: rtl/input_p4_interface.sv
// Ingress dispatcher: buffers the arbiter stream and steers whole packets to one of
// five virtual-switch streams by VLAN ID. Define INPUT_P4_STATS_EN for the drop counter.
module input_p4_interface
    import input_p4_interface_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 304,
    parameter int C_S_AXIS_TUSER_WIDTH = 304,
    parameter int NUM_QUEUES           = 5,
    parameter int DEFAULT_QUEUE        = 0
)(
    input  logic                              axis_aclk,
    input  logic                              axis_resetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_0_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_0_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_0_tuser,
    output logic                              m_axis_0_tvalid,
    output logic                              m_axis_0_tlast,
    input  logic                              m_axis_0_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_1_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_1_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_1_tuser,
    output logic                              m_axis_1_tvalid,
    output logic                              m_axis_1_tlast,
    input  logic                              m_axis_1_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_2_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_2_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_2_tuser,
    output logic                              m_axis_2_tvalid,
    output logic                              m_axis_2_tlast,
    input  logic                              m_axis_2_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_3_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_3_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_3_tuser,
    output logic                              m_axis_3_tvalid,
    output logic                              m_axis_3_tlast,
    input  logic                              m_axis_3_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_4_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_4_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_4_tuser,
    output logic                              m_axis_4_tvalid,
    output logic                              m_axis_4_tlast,
    input  logic                              m_axis_4_tready,
    output logic                              pkt_fwd,
    output logic [31:0]                       drop_count
);
    localparam int FIFO_WIDTH      = 1 + C_S_AXIS_TUSER_WIDTH + C_S_AXIS_DATA_WIDTH/8 + C_S_AXIS_DATA_WIDTH;
    localparam int FIFO_DEPTH_BITS = log2(MAX_PKT_SIZE / (C_S_AXIS_DATA_WIDTH/8));

    logic [FIFO_WIDTH-1:0]             fifo_dout;
    logic                              fifo_rd_en;
    logic                              fifo_empty;
    logic                              fifo_nearly_full;
    logic                              unused_full;
    logic                              unused_prog_full;
    logic [C_M_AXIS_DATA_WIDTH-1:0]    head_tdata;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0]  head_tkeep;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]   head_tuser;
    logic                              head_tlast;
    logic                              dec_drop;
    logic [2:0]                        dec_dst;
    logic [4:0]                        m_tready;
    logic [4:0]                        tvalid_vec;
    logic [1:0]                        state_q, state_d;
    logic [2:0]                        cur_dst_q, cur_dst_d;
    logic                              pkt_fwd_q, pkt_fwd_d;

    fallthrough_small_fifo #(
        .WIDTH          (FIFO_WIDTH),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_ingress_fifo (
        .din         ({s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata}),
        .wr_en       (s_axis_tvalid & ~fifo_nearly_full),
        .rd_en       (fifo_rd_en),
        .dout        (fifo_dout),
        .full        (unused_full),
        .nearly_full (fifo_nearly_full),
        .prog_full   (unused_prog_full),
        .empty       (fifo_empty),
        .reset       (~axis_resetn),
        .clk         (axis_aclk)
    );

    assign s_axis_tready = ~fifo_nearly_full;
    assign {head_tlast, head_tuser, head_tkeep, head_tdata} = fifo_dout;

    input_p4_decode #(
        .NUM_QUEUES    (NUM_QUEUES),
        .DEFAULT_QUEUE (DEFAULT_QUEUE)
    ) u_decode (
        .vlan_hdr (head_tdata[VLAN_HDR_LSB +: 32]),
        .drop     (dec_drop),
        .dst      (dec_dst)
    );

    assign m_tready = {m_axis_4_tready, m_axis_3_tready, m_axis_2_tready, m_axis_1_tready, m_axis_0_tready};

    // The head word is held while IDLE waits for ready, so the decode stays stable.
    always_comb begin
        state_d    = state_q;
        cur_dst_d  = cur_dst_q;
        pkt_fwd_d  = 1'b0;
        fifo_rd_en = 1'b0;
        tvalid_vec = '0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (dec_drop) begin
                        fifo_rd_en = 1'b1;
                        if (!head_tlast) state_d = ST_DROP;
                    end else begin
                        tvalid_vec[dec_dst] = 1'b1;
                        if (m_tready[dec_dst]) begin
                            fifo_rd_en = 1'b1;
                            pkt_fwd_d  = 1'b1;
                            cur_dst_d  = dec_dst;
                            if (!head_tlast) state_d = ST_FWD;
                        end
                    end
                end
            end
            ST_FWD: begin
                tvalid_vec[cur_dst_q] = ~fifo_empty;
                if (!fifo_empty && m_tready[cur_dst_q]) begin
                    fifo_rd_en = 1'b1;
                    if (head_tlast) state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                fifo_rd_en = ~fifo_empty;
                if (!fifo_empty && head_tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q   <= ST_IDLE;
            cur_dst_q <= '0;
            pkt_fwd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_dst_q <= cur_dst_d;
            pkt_fwd_q <= pkt_fwd_d;
        end
    end

    assign pkt_fwd = pkt_fwd_q;

`ifdef INPUT_P4_STATS_EN
    logic [31:0] drop_count_q;
    logic        drop_first;

    assign drop_first = (state_q == ST_IDLE) & ~fifo_empty & dec_drop;

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn)                                   drop_count_q <= '0;
        else if (drop_first && drop_count_q != 32'hFFFF_FFFF) drop_count_q <= drop_count_q + 32'd1;
    end

    assign drop_count = drop_count_q;
`else
    assign drop_count = 32'd0;
`endif

    // All streams carry the FIFO head; only tvalid distinguishes the destination.
    assign m_axis_0_tdata = head_tdata;  assign m_axis_0_tkeep = head_tkeep;
    assign m_axis_0_tuser = head_tuser;  assign m_axis_0_tlast = head_tlast;
    assign m_axis_1_tdata = head_tdata;  assign m_axis_1_tkeep = head_tkeep;
    assign m_axis_1_tuser = head_tuser;  assign m_axis_1_tlast = head_tlast;
    assign m_axis_2_tdata = head_tdata;  assign m_axis_2_tkeep = head_tkeep;
    assign m_axis_2_tuser = head_tuser;  assign m_axis_2_tlast = head_tlast;
    assign m_axis_3_tdata = head_tdata;  assign m_axis_3_tkeep = head_tkeep;
    assign m_axis_3_tuser = head_tuser;  assign m_axis_3_tlast = head_tlast;
    assign m_axis_4_tdata = head_tdata;  assign m_axis_4_tkeep = head_tkeep;
    assign m_axis_4_tuser = head_tuser;  assign m_axis_4_tlast = head_tlast;

    assign m_axis_0_tvalid = tvalid_vec[0];
    assign m_axis_1_tvalid = tvalid_vec[1];
    assign m_axis_2_tvalid = tvalid_vec[2];
    assign m_axis_3_tvalid = tvalid_vec[3];
    assign m_axis_4_tvalid = tvalid_vec[4];

endmodule

// File: tb/tb_input_p4_interface.sv
// Bench for input_p4_interface: a packet-level steering model checks every output
// beat and pkt_fwd each cycle; directed tests pin the model with literal counts.
`timescale 1ns/1ps
module tb_input_p4_interface;
    localparam int DW = 256;
    localparam int KW = 32;
    localparam int UW = 304;
    localparam int NQ = 5;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic [UW-1:0] s_tuser;
    logic          s_tvalid, s_tlast, s_tready;
    logic [DW-1:0] m_tdata [NQ];
    logic [KW-1:0] m_tkeep [NQ];
    logic [UW-1:0] m_tuser [NQ];
    logic          m_tvalid [NQ];
    logic          m_tlast [NQ];
    logic          m_tready [NQ];
    logic          pkt_fwd;
    logic [31:0]   drop_count;

    always #5 clk = ~clk;

    input_p4_interface dut (
        .axis_aclk(clk), .axis_resetn(resetn),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_0_tdata(m_tdata[0]), .m_axis_0_tkeep(m_tkeep[0]), .m_axis_0_tuser(m_tuser[0]),
        .m_axis_0_tvalid(m_tvalid[0]), .m_axis_0_tlast(m_tlast[0]), .m_axis_0_tready(m_tready[0]),
        .m_axis_1_tdata(m_tdata[1]), .m_axis_1_tkeep(m_tkeep[1]), .m_axis_1_tuser(m_tuser[1]),
        .m_axis_1_tvalid(m_tvalid[1]), .m_axis_1_tlast(m_tlast[1]), .m_axis_1_tready(m_tready[1]),
        .m_axis_2_tdata(m_tdata[2]), .m_axis_2_tkeep(m_tkeep[2]), .m_axis_2_tuser(m_tuser[2]),
        .m_axis_2_tvalid(m_tvalid[2]), .m_axis_2_tlast(m_tlast[2]), .m_axis_2_tready(m_tready[2]),
        .m_axis_3_tdata(m_tdata[3]), .m_axis_3_tkeep(m_tkeep[3]), .m_axis_3_tuser(m_tuser[3]),
        .m_axis_3_tvalid(m_tvalid[3]), .m_axis_3_tlast(m_tlast[3]), .m_axis_3_tready(m_tready[3]),
        .m_axis_4_tdata(m_tdata[4]), .m_axis_4_tkeep(m_tkeep[4]), .m_axis_4_tuser(m_tuser[4]),
        .m_axis_4_tvalid(m_tvalid[4]), .m_axis_4_tlast(m_tlast[4]), .m_axis_4_tready(m_tready[4]),
        .pkt_fwd(pkt_fwd), .drop_count(drop_count)
    );

    typedef struct {
        int            dst;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    bit    in_first = 1'b1;
    bit    in_drop = 1'b0;
    int    in_dst = 0;
    bit    out_first = 1'b1;
    bit    exp_fwd = 1'b0;
    int    exp_drops = 0;
    int    beat_cnt [NQ];
    int    fwd_cnt = 0;
    bit    saw_stall = 1'b0;
    int    cyc = 0;
    int    first_hs = -1;
    int    last_hs = -1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Steering rule straight from the tag: untagged -> queue 0, VID<5 -> VID, else drop (-1).
    function automatic int model_dst(input logic [DW-1:0] d);
        logic [15:0] tpid;
        logic [11:0] vid;
        tpid = {d[103:96], d[111:104]};
        vid  = {d[115:112], d[127:120]};
        if (tpid != 16'h8100) return 0;
        if (vid < 12'd5) return int'(vid);
        return -1;
    endfunction

    always @(negedge clk) begin
        int nval;
        cyc++;
        if (!resetn) begin
            exp_q.delete();
            in_first = 1'b1; in_drop = 1'b0; out_first = 1'b1; exp_fwd = 1'b0; exp_drops = 0;
        end else begin
            chk("pkt_fwd", pkt_fwd, exp_fwd);
            if (pkt_fwd) fwd_cnt++;
            exp_fwd = 1'b0;
            nval = 0;
            for (int k = 0; k < NQ; k++) begin
                if (m_tvalid[k]) begin
                    nval++;
                    if (exp_q.size() == 0) begin
                        chk($sformatf("tvalid_unexpected_port%0d", k), m_tvalid[k], 1'b0);
                    end else begin
                        chk("beat_dst", k, exp_q[0].dst);
                        chk("beat_data", m_tdata[k], exp_q[0].data);
                        chk("beat_keep", m_tkeep[k], exp_q[0].keep);
                        chk("beat_user", m_tuser[k], exp_q[0].user);
                        chk("beat_last", m_tlast[k], exp_q[0].last);
                        if (m_tready[k]) begin
                            if (out_first) exp_fwd = 1'b1;
                            out_first = exp_q[0].last;
                            void'(exp_q.pop_front());
                            beat_cnt[k]++;
                            if (first_hs < 0) first_hs = cyc;
                            last_hs = cyc;
                        end
                    end
                end
            end
            if (nval > 1) chk("tvalid_count", nval, 1);
            if (!s_tready) saw_stall = 1'b1;
            if (s_tvalid && s_tready) begin
                if (in_first) begin
                    in_dst  = model_dst(s_tdata);
                    in_drop = (in_dst < 0);
                    if (in_drop) exp_drops++;
                end
                if (!in_drop) exp_q.push_back('{in_dst, s_tdata, s_tkeep, s_tuser, s_tlast});
                in_first = s_tlast;
            end
        end
    end

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [UW-1:0] rand_user();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
        return r[UW-1:0];
    endfunction

    function automatic logic [DW-1:0] make_hdr(input logic [15:0] tpid, input logic [11:0] vid);
        logic [DW-1:0] d;
        d = rand_data();
        d[103:96]  = tpid[15:8];
        d[111:104] = tpid[7:0];
        d[115:112] = vid[11:8];
        d[127:120] = vid[7:0];
        return d;
    endfunction

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic drive_beat(input logic [DW-1:0] d, input logic last);
        bit ok;
        int guard;
        guard = 0;
        s_tvalid = 1'b1; s_tdata = d; s_tlast = last;
        s_tkeep = $urandom; s_tuser = rand_user();
        do begin
            @(negedge clk); ok = s_tready;
            @(posedge clk); #1;
            guard++;
        end while (!ok && guard < 3000);
        if (!ok) chk("ingress_accept_timeout", ok, 1'b1);
    endtask

    task automatic send_pkt(input logic [15:0] tpid, input logic [11:0] vid, input int nbeats);
        for (int b = 0; b < nbeats; b++)
            drive_beat((b == 0) ? make_hdr(tpid, vid) : rand_data(), b == nbeats - 1);
        s_tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 1000) begin @(posedge clk); g++; end
        chk({name, "_drain"}, exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        for (int k = 0; k < NQ; k++) beat_cnt[k] = 0;
        fwd_cnt = 0; saw_stall = 1'b0; first_hs = -1; last_hs = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_dc;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0; s_tuser = '0;
        for (int k = 0; k < NQ; k++) m_tready[k] = 1'b1;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NQ; k++) chk($sformatf("reset_tvalid%0d", k), m_tvalid[k], 1'b0);
        chk("reset_pkt_fwd", pkt_fwd, 1'b0);
        chk("reset_drop_count", drop_count, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("reset_tready", s_tready, 1'b1);

        // Tagged VID=2, 3 beats; other readies low must not matter
        clear_stats();
        for (int k = 0; k < NQ; k++) m_tready[k] = (k == 2);
        send_pkt(16'h8100, 12'd2, 3);
        wait_drain("t1");
        chk("t1_port2_beats", beat_cnt[2], 3);
        chk("t1_other_beats", beat_cnt[0] + beat_cnt[1] + beat_cnt[3] + beat_cnt[4], 0);
        chk("t1_fwd_pulses", fwd_cnt, 1);
        for (int k = 0; k < NQ; k++) m_tready[k] = 1'b1;

        // Untagged 2-beat packet (VID bits irrelevant) -> default queue 0
        clear_stats();
        send_pkt(16'h0800, 12'd7, 2);
        wait_drain("t2");
        chk("t2_port0_beats", beat_cnt[0], 2);
        chk("t2_drop_count", drop_count, 32'd0);

        // Tagged VID=9, 4 beats, then VID=5 (first out-of-range) single beat: both dropped
        clear_stats();
        send_pkt(16'h8100, 12'd9, 4);
        repeat (8) @(posedge clk); #1;
        chk("t3_model_drops", exp_drops, 1);
`ifdef INPUT_P4_STATS_EN
        exp_dc = 1;
`else
        exp_dc = 0;
`endif
        chk("t3_drop_count_vid9", drop_count, exp_dc);
        send_pkt(16'h8100, 12'd5, 1);
        repeat (8) @(posedge clk); #1;
`ifdef INPUT_P4_STATS_EN
        exp_dc = 2;
`else
        exp_dc = 0;
`endif
        chk("t3_drop_count_vid5", drop_count, exp_dc);
        chk("t3_no_beats", beat_cnt[0] + beat_cnt[1] + beat_cnt[2] + beat_cnt[3] + beat_cnt[4], 0);

        // VID=1 long packet with port 1 stalled for 100 cycles: ingress must backpressure
        clear_stats();
        fork
            send_pkt(16'h8100, 12'd1, 70);
            begin
                m_tready[1] = 1'b0;
                repeat (100) @(posedge clk);
                #1 m_tready[1] = 1'b1;
            end
        join
        wait_drain("t4");
        chk("t4_stall_seen", saw_stall, 1'b1);
        chk("t4_port1_beats", beat_cnt[1], 70);
        chk("t4_fwd_pulses", fwd_cnt, 1);

        // Back-to-back single-beat packets alternating VID 0 / VID 4
        clear_stats();
        for (int i = 0; i < 8; i++) send_pkt(16'h8100, (i % 2 == 0) ? 12'd0 : 12'd4, 1);
        wait_drain("t5");
        chk("t5_fwd_pulses", fwd_cnt, 8);
        chk("t5_port0_beats", beat_cnt[0], 4);
        chk("t5_port4_beats", beat_cnt[4], 4);
        chk("t5_span_cycles", last_hs - first_hs, 7);

        // Reset in the middle of a VID=3 packet held at the head by port 3 backpressure
        clear_stats();
        m_tready[3] = 1'b0;
        drive_beat(make_hdr(16'h8100, 12'd3), 1'b0);
        drive_beat(rand_data(), 1'b0);
        s_tvalid = 1'b0;
        chk("t6_tvalid3_before_reset", m_tvalid[3], 1'b1);
        resetn = 1'b0;
        #1;
        for (int k = 0; k < NQ; k++) chk($sformatf("t6_tvalid%0d_in_reset", k), m_tvalid[k], 1'b0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        m_tready[3] = 1'b1;
        @(posedge clk); #1;
        clear_stats();
        send_pkt(16'h8100, 12'd3, 1);
        wait_drain("t6");
        chk("t6_port3_beats", beat_cnt[3], 1);
        chk("t6_fwd_pulses", fwd_cnt, 1);
        chk("t6_drop_count", drop_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
